exc_unit: RTL and testbench

EXC_UNIT -- requirements
Module: exc_unit

---
 rtl/exc_if.sv | 31 +++
 rtl/exc_unit.sv | 123 ++++++++++++
 tb/tb_exc_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/exc_if.sv
// Exception unit bus: decoded event flags and CP0 inputs in, CP0 request and PC redirect out.
// Handshake: exc_req is held with cause/exc_pc stable until cp0_ack is sampled high; cp0_ack is ignored while exc_req is low.
interface exc_if;
  logic        syscall;
  logic        brk;
  logic        teq;
  logic        eret;
  logic        rs_eq_rt;
  logic        ext_irq;
  logic [31:0] status;
  logic [31:0] pc;
  logic [31:0] epc;
  logic        cp0_ack;
  logic        exc_req;
  logic [31:0] cause;
  logic [31:0] exc_pc;
  logic        stall;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        ack_err;

  modport master (
    output syscall, brk, teq, eret, rs_eq_rt, ext_irq, status, pc, epc, cp0_ack,
    input  exc_req, cause, exc_pc, stall, pc_sel, pc_target, ack_err
  );

  modport slave (
    input  syscall, brk, teq, eret, rs_eq_rt, ext_irq, status, pc, epc, cp0_ack,
    output exc_req, cause, exc_pc, stall, pc_sel, pc_target, ack_err
  );
endinterface

// File: rtl/exc_unit.sv
// Exception sequencer: qualifies events, hands cause/pc to CP0, then redirects to the handler
// or returns to EPC on eret. dbg_state exposes the FSM state (0 IDLE, 1 REQ, 2 VEC, 3 RET).
module exc_unit #(
  parameter logic [31:0] HANDLER     = 32'h0000_0004,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  exc_if.slave       bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, VEC = 2'd2, RET = 2'd3} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  wait_inc;
  logic [31:0] cause_q, exc_pc_q;
  logic        ack_err_q, ack_err_d;
  logic        take;
  logic        latch;
  logic [4:0]  code;
  logic        unused_status;

  assign unused_status = ^bus.status[31:5];
  assign wait_inc      = wait_q + 8'd1;

  // Fixed priority: syscall > break > trap > interrupt, all gated by global IE.
  always_comb begin
    take = 1'b0;
    code = 5'd0;
    if (bus.status[0]) begin
      if (bus.syscall && bus.status[1]) begin
        take = 1'b1;
        code = 5'd8;
      end else if (bus.brk && bus.status[2]) begin
        take = 1'b1;
        code = 5'd9;
      end else if (bus.teq && bus.rs_eq_rt && bus.status[3]) begin
        take = 1'b1;
        code = 5'd13;
      end else if (bus.ext_irq && bus.status[4]) begin
        take = 1'b1;
        code = 5'd0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    ack_err_d     = ack_err_q;
    latch         = 1'b0;
    bus.exc_req   = 1'b0;
    bus.stall     = 1'b0;
    bus.pc_sel    = 1'b0;
    bus.pc_target = 32'h0;
    case (state_q)
      IDLE: begin
        // An exception always wins over a simultaneous eret.
        if (take) begin
          state_d = REQ;
          latch   = 1'b1;
          wait_d  = 8'd0;
        end else if (bus.eret) begin
          state_d = RET;
        end
      end
      REQ: begin
        bus.exc_req = 1'b1;
        bus.stall   = 1'b1;
        if (bus.cp0_ack) begin
          state_d = VEC;
          wait_d  = 8'd0;
        end else if (wait_inc == TIMEOUT_CNT) begin
          state_d   = IDLE;
          wait_d    = 8'd0;
          ack_err_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      VEC: begin
        bus.stall     = 1'b1;
        bus.pc_sel    = 1'b1;
        bus.pc_target = HANDLER;
        state_d       = IDLE;
      end
      RET: begin
        bus.pc_sel    = 1'b1;
        bus.pc_target = bus.epc;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= 8'd0;
      cause_q   <= 32'h0;
      exc_pc_q  <= 32'h0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ack_err_q <= ack_err_d;
      if (latch) begin
        cause_q  <= {25'b0, code, 2'b00};
        exc_pc_q <= bus.pc;
      end
    end
  end

  assign bus.cause   = cause_q;
  assign bus.exc_pc  = exc_pc_q;
  assign bus.ack_err = ack_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_exc_unit.sv
// Directed bench for exc_unit: a vector table for single events plus sequences for timeout and reset.
module tb_exc_unit;
  localparam logic [31:0] HANDLER = 32'h0000_0004;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         total;
  int         bad;
  logic [31:0] last_cause;
  logic [31:0] last_pc;

  exc_if bus ();

  exc_unit #(.HANDLER(HANDLER), .ACK_TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // kind: 0 nothing happens, 1 exception, 2 eret return
  typedef struct {
    logic [31:0] status;
    logic        sc, bk, tq, req, irq, er;
    logic [31:0] pc, epc;
    int          ack_at;
    int          kind;
    logic [31:0] exp_cause;
  } vec_t;

  vec_t vecs[13];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.syscall = 1'b0; bus.brk = 1'b0; bus.teq = 1'b0; bus.eret = 1'b0;
    bus.rs_eq_rt = 1'b0; bus.ext_irq = 1'b0; bus.cp0_ack = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    bus.status = v.status; bus.pc = v.pc; bus.epc = v.epc;
    bus.syscall = v.sc; bus.brk = v.bk; bus.teq = v.tq;
    bus.rs_eq_rt = v.req; bus.ext_irq = v.irq; bus.eret = v.er;
    @(negedge clk);
    clear_inputs();
    if (v.kind == 1) begin
      check($sformatf("v%0d_cause", i), bus.cause, v.exp_cause);
      check($sformatf("v%0d_exc_pc", i), bus.exc_pc, v.pc);
      check($sformatf("v%0d_stall", i), {31'b0, bus.stall}, 32'd1);
      check($sformatf("v%0d_pc_sel_req", i), {31'b0, bus.pc_sel}, 32'd0);
      for (int k = 1; k <= v.ack_at; k++) begin
        check($sformatf("v%0d_exc_req_c%0d", i, k), {31'b0, bus.exc_req}, 32'd1);
        if (k == v.ack_at) bus.cp0_ack = 1'b1;
        @(negedge clk);
        bus.cp0_ack = 1'b0;
      end
      check($sformatf("v%0d_vec_pc_sel", i), {31'b0, bus.pc_sel}, 32'd1);
      check($sformatf("v%0d_vec_target", i), bus.pc_target, HANDLER);
      check($sformatf("v%0d_vec_stall", i), {31'b0, bus.stall}, 32'd1);
      check($sformatf("v%0d_vec_exc_req", i), {31'b0, bus.exc_req}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_idle_state", i), {30'b0, dbg_state}, 32'd0);
      check($sformatf("v%0d_idle_pc_sel", i), {31'b0, bus.pc_sel}, 32'd0);
      check($sformatf("v%0d_idle_target", i), bus.pc_target, 32'h0);
      check($sformatf("v%0d_keep_cause", i), bus.cause, v.exp_cause);
      check($sformatf("v%0d_keep_exc_pc", i), bus.exc_pc, v.pc);
      last_cause = v.exp_cause;
      last_pc    = v.pc;
    end else if (v.kind == 2) begin
      check($sformatf("v%0d_ret_pc_sel", i), {31'b0, bus.pc_sel}, 32'd1);
      check($sformatf("v%0d_ret_target", i), bus.pc_target, v.epc);
      check($sformatf("v%0d_ret_stall", i), {31'b0, bus.stall}, 32'd0);
      check($sformatf("v%0d_ret_exc_req", i), {31'b0, bus.exc_req}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_ret_done_pc_sel", i), {31'b0, bus.pc_sel}, 32'd0);
      check($sformatf("v%0d_ret_done_state", i), {30'b0, dbg_state}, 32'd0);
    end else begin
      check($sformatf("v%0d_no_exc_req", i), {31'b0, bus.exc_req}, 32'd0);
      check($sformatf("v%0d_no_stall", i), {31'b0, bus.stall}, 32'd0);
      check($sformatf("v%0d_no_pc_sel", i), {31'b0, bus.pc_sel}, 32'd0);
      check($sformatf("v%0d_no_state", i), {30'b0, dbg_state}, 32'd0);
      check($sformatf("v%0d_no_cause", i), bus.cause, last_cause);
      check($sformatf("v%0d_no_exc_pc", i), bus.exc_pc, last_pc);
    end
  endtask

  initial begin
    int n;
    total = 0;
    bad = 0;
    last_cause = 32'h0;
    last_pc = 32'h0;
    clear_inputs();
    bus.status = 32'h0; bus.pc = 32'h0; bus.epc = 32'h0;
    rst = 1'b0;

    //                status  sc bk tq req irq er  pc        epc       ack kind cause
    vecs[0]  = '{32'h03, 1, 0, 0, 0, 0, 0, 32'h040, 32'h0000, 2, 1, 32'h20};
    vecs[1]  = '{32'h0F, 0, 0, 1, 0, 0, 0, 32'h044, 32'h0000, 0, 0, 32'h00};
    vecs[2]  = '{32'h0F, 0, 0, 1, 1, 0, 0, 32'h080, 32'h0000, 1, 1, 32'h34};
    vecs[3]  = '{32'h1F, 1, 1, 0, 0, 1, 1, 32'h100, 32'h1234, 1, 1, 32'h20};
    vecs[4]  = '{32'h01, 0, 1, 0, 0, 0, 0, 32'h104, 32'h0000, 0, 0, 32'h00};
    vecs[5]  = '{32'h00, 0, 0, 0, 0, 0, 1, 32'h108, 32'h1234, 0, 2, 32'h00};
    vecs[6]  = '{32'h05, 0, 1, 0, 0, 0, 0, 32'h200, 32'h0000, 3, 1, 32'h24};
    vecs[7]  = '{32'h11, 0, 0, 0, 0, 1, 0, 32'h300, 32'h0000, 1, 1, 32'h00};
    vecs[8]  = '{32'h1F, 0, 1, 1, 1, 1, 0, 32'h304, 32'h0000, 1, 1, 32'h24};
    vecs[9]  = '{32'h1E, 1, 0, 0, 0, 0, 0, 32'h308, 32'h0000, 0, 0, 32'h00};
    vecs[10] = '{32'h19, 0, 0, 1, 1, 1, 0, 32'h30C, 32'h0000, 2, 1, 32'h34};
    vecs[11] = '{32'h1F, 0, 0, 0, 0, 1, 1, 32'h310, 32'hABCD, 1, 1, 32'h00};
    vecs[12] = '{32'h1F, 0, 0, 0, 0, 0, 1, 32'h314, 32'hABCD, 0, 2, 32'h00};

    #1 rst = 1'b1;
    #1;
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    check("rst_exc_req", {31'b0, bus.exc_req}, 32'd0);
    check("rst_cause", bus.cause, 32'h0);
    check("rst_exc_pc", bus.exc_pc, 32'h0);
    check("rst_pc_target", bus.pc_target, 32'h0);
    check("rst_ack_err", {31'b0, bus.ack_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i);

    // Ack timeout: flags and ack-less REQ cycles; a brk arriving mid-REQ must be ignored.
    @(negedge clk);
    bus.status = 32'h07; bus.pc = 32'h500; bus.syscall = 1'b1;
    @(negedge clk);
    bus.syscall = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && bus.exc_req; k++) begin
      n++;
      if (k == 2) begin
        bus.brk = 1'b1;
        bus.pc  = 32'h900;
      end
      @(negedge clk);
      bus.brk = 1'b0;
    end
    check("timeout_len", n, 32'd15);
    check("timeout_ack_err", {31'b0, bus.ack_err}, 32'd1);
    check("timeout_state", {30'b0, dbg_state}, 32'd0);
    check("timeout_no_redirect", {31'b0, bus.pc_sel}, 32'd0);
    check("timeout_cause", bus.cause, 32'h20);
    check("timeout_exc_pc", bus.exc_pc, 32'h500);

    // cp0_ack outside REQ does nothing.
    bus.cp0_ack = 1'b1;
    @(negedge clk);
    bus.cp0_ack = 1'b0;
    check("idle_ack_state", {30'b0, dbg_state}, 32'd0);
    check("idle_ack_pc_sel", {31'b0, bus.pc_sel}, 32'd0);
    run_vec(0);
    check("ack_err_sticky", {31'b0, bus.ack_err}, 32'd1);
    rst = 1'b1;
    #1;
    check("ack_err_cleared", {31'b0, bus.ack_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_cause = 32'h0;
    last_pc = 32'h0;

    // Reset in the middle of REQ.
    @(negedge clk);
    bus.status = 32'h03; bus.pc = 32'h600; bus.syscall = 1'b1;
    @(negedge clk);
    bus.syscall = 1'b0;
    check("mid_req_exc_req", {31'b0, bus.exc_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_req_rst_exc_req", {31'b0, bus.exc_req}, 32'd0);
    check("mid_req_rst_stall", {31'b0, bus.stall}, 32'd0);
    check("mid_req_rst_cause", bus.cause, 32'h0);
    check("mid_req_rst_exc_pc", bus.exc_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_req_after_pc_sel", {31'b0, bus.pc_sel}, 32'd0);
    check("mid_req_after_state", {30'b0, dbg_state}, 32'd0);

    // Reset in the middle of VEC.
    @(negedge clk);
    bus.status = 32'h05; bus.pc = 32'h700; bus.brk = 1'b1;
    @(negedge clk);
    bus.brk = 1'b0;
    bus.cp0_ack = 1'b1;
    @(negedge clk);
    bus.cp0_ack = 1'b0;
    check("mid_vec_pc_sel", {31'b0, bus.pc_sel}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_vec_rst_pc_sel", {31'b0, bus.pc_sel}, 32'd0);
    check("mid_vec_rst_target", bus.pc_target, 32'h0);
    check("mid_vec_rst_stall", {31'b0, bus.stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_vec_after_pc_sel", {31'b0, bus.pc_sel}, 32'd0);
    @(negedge clk);
    check("mid_vec_after_state", {30'b0, dbg_state}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
